expr_eval: RTL
==============

# expr_eval

Streaming evaluator for single-digit ASCII arithmetic expressions of the form `digit ( op digit )*`, with op ∈ {`+`, `*`} and `*` binding tighter than `+`. It sits directly downstream of the character-level syntax recognizer and consumes the same byte stream, one character per accepted clock. It keeps a running value of the expression received so far, with a sticky syntax-error flag and a sticky overflow flag.

## Interface
- `W`, 16: result width in bits; all arithmetic is modulo 2^W.
- `clk`, in, 1: clock, rising edge.
- `clr`, in, 1: reset, asynchronous, active-high.
- `restart`, in, 1: synchronous clear to the reset state; has priority over `in_valid`.
- `in_valid`, in, 1: `in` is consumed on this edge.
- `in`, in, 8: ASCII character.
- `result`, out, W: current expression value, `S + P` (mod 2^W).
- `valid`, out, 1: `result` is the value of a complete, well-formed expression.
- `err`, out, 1: sticky syntax error.
- `ovf`, out, 1: sticky arithmetic wrap.

## Operation
- Registers:
  - `S` (W bits): sum of the closed terms.
  - `P` (W bits): the open product term.
  - `mul` (1 bit): the pending operator is `*`.
  - `state`: one-hot, one of EXP_DIG, EXP_OP, ERR.
- Reset or `restart` values: `S=0`, `P=0`, `mul=0`, `state=EXP_DIG`, `err=0`, `ovf=0`.
- Character classes:
  - digit: 48..57, value `in-48`.
  - plus: 43.
  - mul: 42.
  - anything else: illegal.
- Transitions apply only when `in_valid=1`. With `in_valid=0`, all registers hold.
- In EXP_DIG:
  - digit with `mul=0`: `P<=d`, go to EXP_OP.
  - digit with `mul=1`: `P<=P*d` truncated to W bits, go to EXP_OP. Set `ovf` if the full (W+4)-bit product ≥ 2^W.
  - any other character: go to ERR.
- In EXP_OP:
  - plus: `S<=S+P`, `P<=0`, `mul<=0`, go to EXP_DIG. Set `ovf` on carry out.
  - mul: `mul<=1`, go to EXP_DIG.
  - any other character, including a digit: go to ERR.
- ERR is absorbing until `clr` or `restart`. `S`, `P` and `ovf` freeze in ERR.
- Output decode:
  - `valid = (state==EXP_OP)`.
  - `err = (state==ERR)`.
  - `result = S+P`, combinational from registers, truncated to W bits. `result` is meaningful only while `valid=1`.
- Reset output values: `result=0`, `valid=0`, `err=0`, `ovf=0`.

## Timing
- Latency is 1 cycle: a character sampled at edge k is reflected in `result`, `valid` and `err` after edge k.
- This lags the upstream recognizer's combinational accept flag by exactly one cycle.
- One character per cycle is sustained; there is no backpressure.
- `clr` asserted mid-expression forces the reset state immediately, independent of `clk`.
- `restart` and `in_valid` high on the same edge: `restart` wins and the character is dropped.
- Empty expression (reset, no characters yet): `valid=0`, `err=0`.
- A trailing operator gives `valid=0` until the next digit arrives.
- Wrap-around: `P*d` and `S+P` truncate silently to W bits. `ovf` latches and never clears except on reset or `restart`.

## Structure
- Shared package `expr_pkg`:
  - ASCII constants: `CH_0=48`, `CH_9=57`, `CH_PLUS=43`, `CH_MUL=42`.
  - State one-hot encodings: EXP_DIG=3'b001, EXP_OP=3'b010, ERR=3'b100.
- One natural sub-module, `ascii_class`: purely combinational; `in[7:0]` → `is_digit`, `is_plus`, `is_mul`, `dval[3:0]`. It is reusable by the upstream recognizer.
- Top level holds the FSM, the `S`/`P`/`mul` datapath and the flags.

## Test plan
- `1+2*3`, one character per cycle → after the last edge: `result=7`, `valid=1`, `err=0`, `ovf=0`.
- `2*3*4+5` with `in_valid` dropped for 2 cycles between `4` and `+`:
  - `result=24`, `valid=1` while stalled.
  - Final `result=29`, `valid=1`.
- `+1` → `err=1` after the first edge; it stays 1 after `1`; `valid=0` throughout.
- `1++`, `12` and `1#` → each gives `err=1` on the offending character.
- `W=16`:
  - `9*9*9*9*9` → `result=59049`, `ovf=0`.
  - Append `*9` → `result=7153`, `ovf=1`.
- Reset and restart mid-expression:
  - `3*`, then `clr` pulsed between edges → `result=0`, `valid=0`, `err=0` immediately.
  - `restart` together with `in_valid` and `in=5` → the character is dropped and the block is in the reset state.

Source files
------------

// File: rtl/expr_pkg.sv
// expr_pkg -- shared definitions for the ASCII expression evaluator and the
// upstream character-level recognizer.
//   * ASCII constants for the legal character classes
//   * one-hot FSM state encoding
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'd48;
  localparam logic [7:0] CH_9    = 8'd57;
  localparam logic [7:0] CH_PLUS = 8'd43;
  localparam logic [7:0] CH_MUL  = 8'd42;

  // One-hot parser state: waiting for a digit, waiting for an operator,
  // or stuck in the syntax-error state.
  typedef enum logic [2:0] {
    EXP_DIG = 3'b001,
    EXP_OP  = 3'b010,
    ERR     = 3'b100
  } state_e;

endpackage : expr_pkg

// File: rtl/expr_eval_if.sv
// expr_eval_if -- character stream in, evaluation status out.
//   restart  : synchronous clear, wins over in_valid
//   in_valid : 'in' is consumed on this clock edge
//   in       : ASCII character
//   result   : S + P of the expression so far (mod 2^W)
//   valid    : result belongs to a complete, well-formed expression
//   err      : sticky syntax error
//   ovf      : sticky arithmetic wrap
// master = character source, slave = evaluator.
interface expr_eval_if #(
  parameter int W = 16
);
  logic         restart;
  logic         in_valid;
  logic [7:0]   in;
  logic [W-1:0] result;
  logic         valid;
  logic         err;
  logic         ovf;

  modport master (
    output restart, in_valid, in,
    input  result, valid, err, ovf
  );

  modport slave (
    input  restart, in_valid, in,
    output result, valid, err, ovf
  );
endinterface : expr_eval_if

// File: rtl/ascii_class.sv
// ascii_class -- purely combinational character classifier, shared with the
// upstream recognizer.
//   in_i       : ASCII character
//   is_digit_o : '0'..'9'
//   is_plus_o  : '+'
//   is_mul_o   : '*'
//   dval_o     : digit value 0..9 (0 when not a digit)
module ascii_class
  import expr_pkg::*;
(
  input  logic [7:0] in_i,
  output logic       is_digit_o,
  output logic       is_plus_o,
  output logic       is_mul_o,
  output logic [3:0] dval_o
);

  logic [7:0] offset;

  assign offset     = in_i - CH_0;
  assign is_digit_o = (in_i >= CH_0) && (in_i <= CH_9);
  assign is_plus_o  = (in_i == CH_PLUS);
  assign is_mul_o   = (in_i == CH_MUL);
  assign dval_o     = is_digit_o ? offset[3:0] : 4'd0;

endmodule : ascii_class

// File: rtl/expr_eval.sv
// expr_eval -- streaming evaluator for "digit (op digit)*" with op in {+,*},
// '*' binding tighter than '+'. One character per accepted cycle, result
// visible one cycle after the character is sampled.
//   clk : rising-edge clock
//   clr : asynchronous, active-high reset
//   bus : expr_eval_if slave (character stream in, result/flags out)
// Datapath: S holds the sum of closed terms, P the open product term, mul
// marks that the next digit multiplies into P instead of starting it.
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);

  logic       is_digit;
  logic       is_plus;
  logic       is_mul;
  logic [3:0] dval;

  ascii_class u_class (
    .in_i       (bus.in),
    .is_digit_o (is_digit),
    .is_plus_o  (is_plus),
    .is_mul_o   (is_mul),
    .dval_o     (dval)
  );

  state_e       state_q, state_d;
  logic [W-1:0] s_q, s_d;
  logic [W-1:0] p_q, p_d;
  logic         mul_q, mul_d;
  logic         ovf_q, ovf_d;

  // Full-width intermediates: the bits above W are the wrap indicators.
  logic [W+3:0] prod;
  logic [W:0]   sum;

  assign prod = {4'd0, p_q} * {{W{1'b0}}, dval};
  assign sum  = {1'b0, s_q} + {1'b0, p_q};

  // NOTE: every state register is written with <= so all of them update from
  // the same pre-edge values; blocking here would chain S/P updates in order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= EXP_DIG;
      s_q     <= '0;
      p_q     <= '0;
      mul_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      p_q     <= p_d;
      mul_q   <= mul_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: all next-state signals are given a hold default before any branch,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    p_d     = p_q;
    mul_d   = mul_q;
    ovf_d   = ovf_q;

    if (bus.restart) begin
      state_d = EXP_DIG;
      s_d     = '0;
      p_d     = '0;
      mul_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (bus.in_valid) begin
      unique case (state_q)
        EXP_DIG: begin
          if (is_digit) begin
            if (mul_q) begin
              p_d = prod[W-1:0];
              if (|prod[W+3:W]) ovf_d = 1'b1;
            end else begin
              p_d = {{(W-4){1'b0}}, dval};
            end
            state_d = EXP_OP;
          end else begin
            state_d = ERR;
          end
        end
        EXP_OP: begin
          if (is_plus) begin
            s_d     = sum[W-1:0];
            p_d     = '0;
            mul_d   = 1'b0;
            if (sum[W]) ovf_d = 1'b1;
            state_d = EXP_DIG;
          end else if (is_mul) begin
            mul_d   = 1'b1;
            state_d = EXP_DIG;
          end else begin
            state_d = ERR;
          end
        end
        // ERR absorbs everything; datapath and flags stay frozen.
        ERR:     state_d = ERR;
        default: state_d = ERR;
      endcase
    end
  end

  assign bus.result = sum[W-1:0];
  assign bus.valid  = (state_q == EXP_OP);
  assign bus.err    = (state_q == ERR);
  assign bus.ovf    = ovf_q;

endmodule : expr_eval
